neuron_mac: RTL and testbench

NEURON_MAC -- requirements
Module: neuron_mac

---
 rtl/neuron_mac_pkg.sv | 22 ++
 rtl/neuron_mac_sat.sv | 44 ++++
 rtl/neuron_mac.sv | 110 +++++++++++
 tb/tb_neuron_mac.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_mac_pkg.sv
//------------------------------------------------------------------------------
// neuron_mac_pkg : Q4.4 constants, data typedef and MAC state encoding
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package neuron_mac_pkg;

  localparam int c_DATA_W    = 8;
  localparam int c_FRAC_BITS = 4;

  typedef logic signed [c_DATA_W-1:0] q44_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/neuron_mac_sat.sv
//------------------------------------------------------------------------------
// neuron_mac_sat : floor-shift of the wide sum to Q4.4, saturate or wrap
// Build option: NEURON_MAC_SAT_EN selects saturation instead of wrap.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module neuron_mac_sat
  import neuron_mac_pkg::*;
#(
  parameter int SUM_W     = 19,
  parameter int FRAC_BITS = c_FRAC_BITS
) (
  input  logic [SUM_W-1:0]    sum_i,
  output logic [c_DATA_W-1:0] z_o
);

  logic signed [SUM_W-1:0] w_shifted;

  assign w_shifted = $signed(sum_i) >>> FRAC_BITS;

`ifdef NEURON_MAC_SAT_EN
  localparam logic signed [SUM_W-1:0] c_MAX = SUM_W'(127);
  localparam logic signed [SUM_W-1:0] c_MIN = SUM_W'(-128);

  always_comb begin
    z_o = w_shifted[c_DATA_W-1:0];
    if (w_shifted > c_MAX) begin
      z_o = 8'h7F;
    end else if (w_shifted < c_MIN) begin
      z_o = 8'h80;
    end
  end
`else
  logic w_unused;

  // Wrap mode keeps only the low byte; the upper bits are intentionally dropped.
  assign z_o      = w_shifted[c_DATA_W-1:0];
  assign w_unused = ^w_shifted[SUM_W-1:c_DATA_W];
`endif

endmodule

`default_nettype wire

// File: rtl/neuron_mac.sv
//------------------------------------------------------------------------------
// neuron_mac : Q4.4 multiply-accumulate neuron with bias and handshaked output
// Build option: NEURON_MAC_SAT_EN (see neuron_mac_sat). Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module neuron_mac
  import neuron_mac_pkg::*;
#(
  parameter int N_INPUTS  = 2,
  parameter int FRAC_BITS = c_FRAC_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic [c_DATA_W-1:0] x_data,
  input  logic [c_DATA_W-1:0] w_data,
  input  logic [c_DATA_W-1:0] bias,
  output logic                z_valid,
  input  logic                z_ready,
  output logic [c_DATA_W-1:0] z_value
);

  localparam int c_ACC_W = 16 + $clog2(N_INPUTS) + 1;
  localparam int c_SUM_W = c_ACC_W + 1;
  localparam int c_CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(N_INPUTS - 1);

  state_e                    state_q, state_d;
  logic signed [c_ACC_W-1:0] acc_q, acc_d;
  logic [c_CNT_W-1:0]        cnt_q, cnt_d;
  logic [c_DATA_W-1:0]       z_value_q, z_value_d;

  q44_t                      w_x, w_w, w_bias;
  logic signed [15:0]        w_prod;
  logic signed [c_ACC_W-1:0] w_acc_sum;
  logic signed [c_SUM_W-1:0] w_sum;
  logic [c_DATA_W-1:0]       w_z_narrow;
  logic                      w_accept;
  logic                      w_last;

  assign x_ready  = (state_q != ST_OUT);
  assign z_valid  = (state_q == ST_OUT);
  assign z_value  = z_value_q;
  assign w_accept = x_valid & x_ready;

  assign w_x    = x_data;
  assign w_w    = w_data;
  assign w_bias = bias;
  assign w_prod = 16'(w_x) * 16'(w_w);

  // The first product of an evaluation replaces the accumulator rather than adding to it.
  assign w_acc_sum = (state_q == ST_IDLE) ? c_ACC_W'(w_prod)
                                          : acc_q + c_ACC_W'(w_prod);
  assign w_sum     = c_SUM_W'(w_acc_sum) + (c_SUM_W'(w_bias) <<< FRAC_BITS);
  assign w_last    = (state_q == ST_IDLE) ? (N_INPUTS == 1) : (cnt_q == c_LAST_CNT);

  neuron_mac_sat #(
    .SUM_W     (c_SUM_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_sat (
    .sum_i (w_sum),
    .z_o   (w_z_narrow)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    z_value_d = z_value_q;
    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (w_accept) begin
          acc_d = w_acc_sum;
          cnt_d = (state_q == ST_IDLE) ? c_CNT_W'(1) : cnt_q + c_CNT_W'(1);
          if (w_last) begin
            state_d   = ST_OUT;
            z_value_d = w_z_narrow;
          end else begin
            state_d = ST_ACC;
          end
        end
      end
      ST_OUT: begin
        if (z_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      z_value_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      z_value_q <= z_value_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac.sv
//------------------------------------------------------------------------------
// tb_neuron_mac : directed vectors with a queue scoreboard and output monitor
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_neuron_mac;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       x_valid = 1'b0;
  logic       z_ready = 1'b1;
  logic [7:0] x_data  = 8'h00;
  logic [7:0] w_data  = 8'h00;
  logic [7:0] bias    = 8'h00;
  logic       x_ready;
  logic       z_valid;
  logic [7:0] z_value;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] val;
    int         due;
    string      name;
  } exp_t;

  exp_t sb[$];

  neuron_mac dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_data  (x_data),
    .w_data  (w_data),
    .bias    (bias),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .z_value (z_value)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present one pair and return just after the edge that accepts it.
  task automatic send(input logic [7:0] x, input logic [7:0] w);
    bit ok;
    ok      = 1'b0;
    x_valid = 1'b1;
    x_data  = x;
    w_data  = w;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (x_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("send_ready_timeout", {31'b0, ok}, 32'd1);
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic push(input string name, input logic [7:0] val);
    exp_t e;
    e.val  = val;
    e.due  = cyc;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic eval2(input string name,
                       input logic [7:0] x0, input logic [7:0] w0,
                       input logic [7:0] x1, input logic [7:0] w1,
                       input logic [7:0] b,  input logic [7:0] exp);
    bias = b;
    send(x0, w0);
    send(x1, w1);
    push(name, exp);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100; t++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check("drain", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on each rising z_valid, value on each handshake.
  initial begin
    bit   prev_zv;
    bit   prev_hs;
    bit   hs;
    exp_t e;
    prev_zv = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_zv = 1'b0;
        prev_hs = 1'b0;
      end else begin
        hs = 1'b0;
        if (prev_hs) check("zvalid_drop_after_hs", {31'b0, z_valid}, 32'd0);
        if (z_valid && !prev_zv) begin
          if (sb.size() == 0) check("unexpected_zvalid", 32'd1, 32'd0);
          else check({sb[0].name, "_latency"}, cyc, sb[0].due);
        end
        if (z_valid && z_ready) begin
          hs = 1'b1;
          if (sb.size() == 0) begin
            check("unexpected_handshake", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check({e.name, "_value"}, {24'b0, z_value}, {24'b0, e.val});
          end
        end
        prev_zv = z_valid;
        prev_hs = hs;
      end
    end
  end

  initial begin
    logic [7:0] exp_big;
`ifdef NEURON_MAC_SAT_EN
    exp_big = 8'h7F;
`else
    exp_big = 8'hE0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_x_ready", {31'b0, x_ready}, 32'd1);
    check("reset_z_valid", {31'b0, z_valid}, 32'd0);
    check("reset_z_value", {24'b0, z_value}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back evaluations with z_ready held high.
    eval2("basic", 8'd16, 8'd32, 8'd16, 8'd32, 8'hD0, 8'h10);
    eval2("big",   8'd127, 8'd127, 8'd127, 8'd127, 8'h00, exp_big);
    eval2("neg",   8'hF0, 8'h10, 8'h00, 8'h05, 8'h00, 8'hF0);
    eval2("floor", 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF);
    wait_drain();

    // Downstream stall with a pair offered the whole time.
    z_ready = 1'b0;
    eval2("stall", 8'd16, 8'd16, 8'd16, 8'd16, 8'h00, 8'h20);
    x_valid = 1'b1;
    x_data  = 8'h55;
    w_data  = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_x_ready", {31'b0, x_ready}, 32'd0);
      check("stall_z_valid", {31'b0, z_valid}, 32'd1);
      check("stall_z_value", {24'b0, z_value}, 32'h20);
    end
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    z_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("stall_back_idle_ready", {31'b0, x_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Reset in the middle of an evaluation.
    bias = 8'h00;
    send(8'd16, 8'd16);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_z_valid", {31'b0, z_valid}, 32'd0);
      check("rst_mid_x_ready", {31'b0, x_ready}, 32'd1);
    end
    @(posedge clk);
    #1;
    eval2("after_rst", 8'd16, 8'd16, 8'd16, 8'd16, 8'h00, 8'h20);
    wait_drain();

    // Gaps between accepts inside one evaluation.
    bias = 8'hD0;
    send(8'd16, 8'd32);
    repeat (2) @(posedge clk);
    #1;
    send(8'd16, 8'd32);
    push("gap", 8'h10);
    wait_drain();

    repeat (3) @(negedge clk);
    check("final_queue_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
